// File: rtl/btb_update_pkg.sv
// Shared definitions for the BTB update path: counter encodings, init FSM
// states, table geometry and entry field offsets.
package btb_update_pkg;

    localparam int INDEX_W = 11;
    localparam int TAG_W   = 2;
    localparam int PC_W    = 13;
    localparam int ENTRY_W = 18;

    localparam int VALID_BIT = 17;
    localparam int STATE_LSB = 15;
    localparam int TAG_LSB   = 13;
    localparam int TGT_LSB   = 0;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic             v,
        input logic [1:0]       st,
        input logic [TAG_W-1:0] tag,
        input logic [PC_W-1:0]  tgt
    );
        logic [ENTRY_W-1:0] e;
        e = '0;
        e[VALID_BIT]             = v;
        e[STATE_LSB +: 2]        = st;
        e[TAG_LSB +: TAG_W]      = tag;
        e[TGT_LSB +: PC_W]       = tgt;
        return e;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating up/down counter step for the branch direction state.
module btb_sat_counter (
    input  logic       inc,
    input  logic [1:0] cur,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
    end

endmodule

// File: rtl/btb_update.sv
// BTB update: resolves the E-stage branch, flags mispredicts and writes the
// predictor table; clears the table after reset. BTB_STATS_EN adds counters.
//
// state | meaning
// INIT  | sweeping the table with zero entries, E stage ignored
// RUN   | normal operation, one registered table write per cycle
module btb_update
    import btb_update_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               validE,
    input  logic               is_branchE,
    input  logic               is_jumpE,
    input  logic               takenE,
    input  logic [PC_W-1:0]    pcE,
    input  logic [PC_W-1:0]    targetE,
    input  logic               hit_predictE,
    input  logic [1:0]         stateE,
    input  logic [PC_W-1:0]    prepcE,
    output logic [PC_W-1:0]    nextpcE,
    output logic               fail_predictE,
    output logic [INDEX_W-1:0] w_addr,
    output logic [ENTRY_W-1:0] w_data,
    output logic               wen,
`ifdef BTB_STATS_EN
    output logic [31:0]        br_count,
    output logic [31:0]        miss_count,
`endif
    output logic               init_busy
);

    init_state_t        fsm;
    logic [INDEX_W-1:0] sweep;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pred_next;
    logic               ct_e;
    logic               pt;
    logic               at;
    logic [1:0]         st_next;
    logic [TAG_W-1:0]   tag;
    logic               wr_req;
    logic [ENTRY_W-1:0] wr_entry;

    assign init_busy = (fsm == INIT);
    assign pc_inc    = pcE + PC_W'(1);
    assign ct_e      = validE & (is_branchE | is_jumpE) & ~init_busy;
    assign pt        = hit_predictE & stateE[1];
    assign at        = is_jumpE | takenE;
    assign pred_next = pt ? prepcE : pc_inc;
    assign nextpcE   = at ? targetE : pc_inc;
    assign tag       = pcE[PC_W-1:INDEX_W];

    assign fail_predictE = validE & ~init_busy & (nextpcE != pred_next);

    btb_sat_counter u_sat (
        .inc (at),
        .cur (stateE),
        .nxt (st_next)
    );

    always_comb begin
        wr_req   = 1'b0;
        wr_entry = '0;
        if (ct_e) begin
            if (hit_predictE) begin
                wr_req   = 1'b1;
                wr_entry = pack_entry(1'b1, st_next, tag, targetE);
            end else if (at) begin
                wr_req   = 1'b1;
                wr_entry = pack_entry(1'b1, is_jumpE ? ST : WT, tag, targetE);
            end
        end else if (validE && !init_busy && hit_predictE) begin
            // A hit on a non-control-transfer is an alias: drop the entry.
            wr_req   = 1'b1;
            wr_entry = pack_entry(1'b0, SNT, tag, '0);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fsm    <= INIT;
            sweep  <= '0;
            wen    <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else begin
            case (fsm)
                INIT: begin
                    wen    <= 1'b1;
                    w_addr <= sweep;
                    w_data <= '0;
                    sweep  <= sweep + INDEX_W'(1);
                    if (sweep == '1) fsm <= RUN;
                end
                RUN: begin
                    wen <= wr_req;
                    if (wr_req) begin
                        w_addr <= pcE[INDEX_W-1:0];
                        w_data <= wr_entry;
                    end
                end
                default: fsm <= INIT;
            endcase
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            if (ct_e)          br_count   <= br_count + 32'd1;
            if (fail_predictE) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update.sv
// Scoreboard bench for btb_update: directed vectors push expectations,
// a negedge monitor pops and compares combinational and write outputs.
module tb_btb_update;

    logic        CLK;
    logic        RSTN;
    logic        validE, is_branchE, is_jumpE, takenE, hit_predictE;
    logic [12:0] pcE, targetE, prepcE;
    logic [1:0]  stateE;
    logic [12:0] nextpcE;
    logic        fail_predictE;
    logic [10:0] w_addr;
    logic [17:0] w_data;
    logic        wen;
    logic        init_busy;
`ifdef BTB_STATS_EN
    logic [31:0] br_count, miss_count;
`endif

    btb_update dut (
        .CLK           (CLK),
        .RSTN          (RSTN),
        .validE        (validE),
        .is_branchE    (is_branchE),
        .is_jumpE      (is_jumpE),
        .takenE        (takenE),
        .pcE           (pcE),
        .targetE       (targetE),
        .hit_predictE  (hit_predictE),
        .stateE        (stateE),
        .prepcE        (prepcE),
        .nextpcE       (nextpcE),
        .fail_predictE (fail_predictE),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .wen           (wen),
`ifdef BTB_STATS_EN
        .br_count      (br_count),
        .miss_count    (miss_count),
`endif
        .init_busy     (init_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    logic [13:0] comb_q[$];
    logic [28:0] wr_q[$];
    logic        comb_strobe = 1'b0;
    logic        wr_mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic br, input logic jmp, input logic tk,
                          input logic [12:0] pc, input logic [12:0] tgt, input logic hit,
                          input logic [1:0] st, input logic [12:0] prepc);
        validE = v; is_branchE = br; is_jumpE = jmp; takenE = tk;
        pcE = pc; targetE = tgt; hit_predictE = hit; stateE = st; prepcE = prepc;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 13'h0, 13'h0, 0, 2'b00, 13'h0);
        comb_strobe = 1'b0;
    endtask

    task automatic vec(input logic v, input logic br, input logic jmp, input logic tk,
                       input logic [12:0] pc, input logic [12:0] tgt, input logic hit,
                       input logic [1:0] st, input logic [12:0] prepc,
                       input logic [12:0] exp_next, input logic exp_fail,
                       input logic exp_wen, input logic [10:0] exp_addr,
                       input logic [17:0] exp_data);
        @(posedge CLK);
        #1;
        set_in(v, br, jmp, tk, pc, tgt, hit, st, prepc);
        comb_q.push_back({exp_fail, exp_next});
        if (exp_wen) wr_q.push_back({exp_addr, exp_data});
        comb_strobe = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against queued expectations.
    initial begin
        logic [13:0] ce;
        logic [28:0] we;
        forever begin
            @(negedge CLK);
            if (comb_strobe) begin
                if (comb_q.size() == 0) begin
                    chk("comb_q_underflow", 32'd1, 32'd0);
                end else begin
                    ce = comb_q.pop_front();
                    chk("nextpcE", {19'd0, nextpcE}, {19'd0, ce[12:0]});
                    chk("fail_predictE", {31'd0, fail_predictE}, {31'd0, ce[13]});
                end
            end
            if (wr_mon_en && wen) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {21'd0, w_addr}, 32'h7fffffff);
                end else begin
                    we = wr_q.pop_front();
                    chk("w_addr", {21'd0, w_addr}, {21'd0, we[28:18]});
                    chk("w_data", {14'd0, w_data}, {14'd0, we[17:0]});
                end
            end
        end
    end

    initial begin
        int bad;
        RSTN = 1'b0;
        // E inputs that would mispredict and write if not ignored during INIT
        set_in(1, 1, 0, 1, 13'h0100, 13'h0200, 1, 2'b11, 13'h0000);
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_init_busy", {31'd0, init_busy}, 32'd1);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_w_addr", {21'd0, w_addr}, 32'd0);
        chk("rst_fail", {31'd0, fail_predictE}, 32'd0);
        @(negedge CLK);
        RSTN = 1'b1;

        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            @(posedge CLK);
            #1;
            if (wen !== 1'b1 || w_addr !== 11'(i) || w_data !== 18'h0 || fail_predictE !== 1'b0)
                bad++;
            if (i < 2047 && init_busy !== 1'b1) bad++;
            if (i == 2040) idle();
        end
        chk("init_sweep_bad", bad, 32'd0);
        chk("init_done_busy", {31'd0, init_busy}, 32'd0);
        @(posedge CLK);
        #1;
        chk("post_init_wen", {31'd0, wen}, 32'd0);
        wr_mon_en = 1'b1;

        //   v br j tk pc        tgt       hit st     prepc     next      fail wen addr     data
        vec(1, 1, 0, 1, 13'h0100, 13'h0200, 0, 2'b00, 13'h0000, 13'h0200, 1, 1, 11'h100, 18'h30200);
        vec(1, 1, 0, 1, 13'h0123, 13'h0456, 1, 2'b11, 13'h0456, 13'h0456, 0, 1, 11'h123, 18'h38456);
        vec(1, 1, 0, 0, 13'h0200, 13'h0300, 1, 2'b00, 13'h0300, 13'h0201, 0, 1, 11'h200, 18'h20300);
        vec(1, 1, 0, 0, 13'h1FFF, 13'h0050, 1, 2'b10, 13'h0050, 13'h0000, 1, 1, 11'h7FF, 18'h2E050);
        vec(1, 0, 0, 0, 13'h0800, 13'h0123, 1, 2'b10, 13'h0900, 13'h0801, 1, 1, 11'h000, 18'h02000);
        vec(1, 0, 1, 0, 13'h0400, 13'h1ABC, 0, 2'b00, 13'h0000, 13'h1ABC, 1, 1, 11'h400, 18'h39ABC);
        vec(1, 1, 0, 0, 13'h0010, 13'h0020, 0, 2'b00, 13'h0000, 13'h0011, 0, 0, 11'h000, 18'h00000);
        vec(1, 1, 0, 1, 13'h0030, 13'h0040, 1, 2'b01, 13'h0040, 13'h0040, 1, 1, 11'h030, 18'h30040);
        vec(1, 1, 0, 1, 13'h0060, 13'h0666, 1, 2'b10, 13'h0777, 13'h0666, 1, 1, 11'h060, 18'h38666);
        vec(0, 1, 0, 1, 13'h0070, 13'h0080, 1, 2'b11, 13'h0000, 13'h0080, 0, 0, 11'h000, 18'h00000);
        vec(1, 0, 0, 0, 13'h0005, 13'h0000, 0, 2'b00, 13'h0000, 13'h0006, 0, 0, 11'h000, 18'h00000);
        vec(1, 0, 0, 0, 13'h0090, 13'h0111, 1, 2'b01, 13'h0222, 13'h0091, 0, 1, 11'h090, 18'h00000);
        @(posedge CLK);
        #1;
        idle();
        repeat (3) @(posedge CLK);
        #1;
        chk("comb_q_empty", comb_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);
`ifdef BTB_STATS_EN
        chk("br_count", br_count, 32'd8);
        chk("miss_count", miss_count, 32'd6);
`endif
        wr_mon_en = 1'b0;

        // Reset in the middle of the sweep.
        @(negedge CLK);
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        for (int j = 0; j < 1100; j++) begin
            @(posedge CLK);
            #1;
            if (w_addr == 11'd1000) break;
        end
        chk("reach_1000", {21'd0, w_addr}, 32'd1000);
        #2;
        RSTN = 1'b0;
        #1;
        chk("mid_rst_wen", {31'd0, wen}, 32'd0);
        chk("mid_rst_addr", {21'd0, w_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, init_busy}, 32'd1);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        chk("restart_addr0", {21'd0, w_addr}, 32'd0);
        chk("restart_wen", {31'd0, wen}, 32'd1);
        @(posedge CLK);
        #1;
        chk("restart_addr1", {21'd0, w_addr}, 32'd1);
        for (int j = 0; j < 2100; j++) begin
            if (init_busy == 1'b0) break;
            @(posedge CLK);
            #1;
        end
        chk("reinit_done", {31'd0, init_busy}, 32'd0);

        // Reset with a write on the port and another decision pending.
        @(posedge CLK);
        #1;
        set_in(1, 1, 0, 1, 13'h0100, 13'h0200, 0, 2'b00, 13'h0000);
        @(posedge CLK);
        #1;
        chk("pend_wen", {31'd0, wen}, 32'd1);
        chk("pend_addr", {21'd0, w_addr}, 32'h100);
        set_in(1, 1, 0, 1, 13'h0123, 13'h0456, 1, 2'b11, 13'h0456);
        RSTN = 1'b0;
        #1;
        chk("drop_wen", {31'd0, wen}, 32'd0);
        @(posedge CLK);
        #1;
        chk("drop_held_wen", {31'd0, wen}, 32'd0);
        chk("drop_held_addr", {21'd0, w_addr}, 32'd0);
        idle();
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        chk("rel_wen", {31'd0, wen}, 32'd1);
        chk("rel_addr0", {21'd0, w_addr}, 32'd0);
        chk("rel_data0", {14'd0, w_data}, 32'd0);
`ifdef BTB_STATS_EN
        chk("stats_rst_br", br_count, 32'd0);
        chk("stats_rst_miss", miss_count, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btb_update.md
BTB_UPDATE -- requirements
Module: btb_update

Interface
REQ-001 CLK  in  1  single clock; all flops rise on posedge CLK.
REQ-002 RSTN  in  1  asynchronous active-low reset.
REQ-003 validE  in  1  E-stage instruction valid.
REQ-004 is_branchE  in  1  conditional branch in E.
REQ-005 is_jumpE  in  1  JAL/JALR in E; is_branchE and is_jumpE are never both 1.
REQ-006 takenE  in  1  resolved branch outcome; ignored when is_jumpE=1.
REQ-007 pcE, targetE  in  13 each  word PC and resolved target (PC[14:2]).
REQ-008 hit_predictE, stateE, prepcE  in  1/2/13  predictor lookup results carried down from F.
REQ-009 nextpcE, fail_predictE  out  13/1  correct next PC and mispredict flag.
REQ-010 w_addr, w_data, wen  out  11/18/1  predictor table write port.
REQ-011 init_busy  out  1  table clear in progress; fetch stalls while 1.

Function
REQ-012 Control-transfer qualifier: ctE = validE & (is_branchE | is_jumpE) & ~init_busy.
REQ-013 Predicted taken: pt = hit_predictE & stateE[1]; predicted next = pt ? prepcE : pcE+1 (13-bit, 1FFF+1 wraps to 0000).
REQ-014 Actual taken: at = is_jumpE | takenE; nextpcE = at ? targetE : pcE+1, combinational.
REQ-015 fail_predictE = validE & ~init_busy & (nextpcE != predicted next), combinational, zero latency; a non-CT instruction with hit_predictE=1 and pt=1 is a mispredict.
REQ-016 w_data packing: {valid[17], state[16:15], tag[14:13]=pcE[12:11], target[12:0]}; w_addr = pcE[10:0].
REQ-017 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; saturates at 00 and 11.
REQ-018 Hit with ctE: write {1, stateE +1 if at else -1 (saturating), tag, targetE}.
REQ-019 Miss with ctE and at: allocate {1, 10 for branch / 11 for jump, tag, targetE}.
REQ-020 Miss with ctE and not taken: no write.
REQ-021 Hit with validE & ~ctE & ~init_busy (stale alias): write {0, 00, tag, 0} to invalidate.
REQ-022 Writes are registered: decision in cycle N drives w_addr/w_data/wen in cycle N+1, one write per cycle, no queueing.
REQ-023 Init FSM states INIT, RUN. INIT: wen=1, w_data=0, w_addr = sweep counter 0..2047, one entry per cycle; after w_addr=2047 moves to RUN; no way back except reset.
REQ-024 init_busy=1 exactly while in INIT (2048 cycles after reset release); E inputs ignored, fail_predictE=0.

Reset
REQ-025 RSTN low at any time, including mid-sweep or with a write pending: FSM=INIT, sweep counter=0, pending write dropped, wen register=0, init_busy=1, stats counters=0.
REQ-026 First posedge after RSTN rises issues the write to address 0.

Configuration
REQ-027 BTB_STATS_EN defined: adds outputs br_count[31:0] (+1 per ctE cycle) and miss_count[31:0] (+1 per fail_predictE cycle), both wrap at 2^32; ports present only when defined.
REQ-028 BTB_STATS_EN undefined: no counters, no ports; all other behaviour identical.

Structure
REQ-029 Shared package holds state encodings (SNT/WNT/WT/ST), FSM state enum, table geometry constants (INDEX_W=11, TAG_W=2, PC_W=13, ENTRY_W=18) and field offsets for entry packing.
REQ-030 One sub-module, btb_sat_counter: 2-bit saturating inc/dec, combinational.

Verification
REQ-031 Reset release -> init_busy high 2048 cycles, wen=1 with w_addr 0..2047 and w_data=0, then init_busy=0, wen=0.
REQ-032 Miss, taken branch pcE=0x0100, targetE=0x0200 -> fail_predictE=1, nextpcE=0x0200; next cycle w_addr=0x100, w_data={1,10,00,0x0200}.
REQ-033 Hit, stateE=11, takenE=1, prepcE=targetE -> fail=0, write state 11; hit, stateE=00, takenE=0 -> fail=0, write state 00 (saturation).
REQ-034 Hit, stateE=10, prepcE=0x0050, takenE=0, pcE=0x1FFF -> fail=1, nextpcE=0x0000, write state 01, tag 11.
REQ-035 Hit, stateE=10, non-CT instruction at pcE=0x0800 -> fail=1, nextpcE=0x0801, write w_addr=0x000 with valid=0.
REQ-036 RSTN pulsed low at sweep address 1000 -> sweep restarts at 0; pulsed low with a write pending -> no write issued.
